dx_stage: RTL and testbench
===========================

Name: dx_stage

Overview:
- Decode-to-execute pipeline stage that sits directly downstream of the 32x32 register file.
- Combinationally drives the regfile read addresses from the fetched instruction.
- Bypasses same-cycle writeback data onto the regfile read data.
- Detects load-use hazards and registers the instruction, PC and operands into the D/X latch consumed by execute.

Parameters:
- DATA_W, 32, operand/PC/instruction width
- REG_AW, 5, register address width
- OP_LW, 5'b01000, load opcode (hazard source)
- OP_SW / OP_BNE / OP_BLT / OP_JR, 5'b00111 / 5'b00010 / 5'b00110 / 5'b00100, opcodes whose source fields remap

Ports:
- clock  in  1  single clock; all state updates on rising edge
- ctrl_reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- fd_valid  in  1  F/D latch holds a real instruction
- fd_pc  in  32  PC of F/D instruction
- fd_insn  in  32  F/D instruction; opcode[31:27], rd[26:22], rs[21:17], rt[16:12]
- ctrl_readRegA  out  5  regfile read address A (combinational)
- ctrl_readRegB  out  5  regfile read address B (combinational)
- data_readRegA  in  32  regfile read data A
- data_readRegB  in  32  regfile read data B
- ctrl_writeEnable  in  1  writeback enable (same net as the regfile write port)
- ctrl_writeReg  in  5  writeback destination
- data_writeReg  in  32  writeback data
- flush  in  1  branch/jump redirect; squash the incoming instruction
- hazard_stall  out  1  load-use stall request to fetch (combinational)
- dx_valid  out  1  D/X latch valid
- dx_pc  out  32  latched PC
- dx_insn  out  32  latched instruction
- dx_opA  out  32  latched operand A
- dx_opB  out  32  latched operand B

Behaviour:
- Reset: while ctrl_reset=0, asynchronously force dx_valid=0 and dx_pc, dx_insn, dx_opA, dx_opB=0. Combinational outputs follow their inputs as usual.
- Address select:
  - ctrl_readRegA = rd when opcode==OP_JR, else rs.
  - ctrl_readRegB = rd when opcode is OP_SW, OP_BNE or OP_BLT, else rt.
- Bypass, per port X in {A,B}:
  - If ctrl_writeEnable=1, ctrl_writeReg!=0 and ctrl_writeReg==ctrl_readRegX, opX_next = data_writeReg.
  - Else if ctrl_readRegX==0, opX_next = 0.
  - Else opX_next = data_readRegX.
- Load-use hazard: hazard_stall = dx_valid & fd_valid & (dx_insn[31:27]==OP_LW) & (dx_insn[26:22]!=0) & (dx_insn[26:22]==ctrl_readRegA | dx_insn[26:22]==ctrl_readRegB).
- Latch update each rising edge, first match wins:
  1. flush=1: dx_valid<=0, dx_insn<=0. Flush dominates stall.
  2. hazard_stall=1: insert bubble (dx_valid<=0, dx_insn<=0). Fetch holds F/D, so the same instruction re-decodes next cycle.
  3. Otherwise: dx_valid<=fd_valid, dx_pc<=fd_pc, dx_insn<=fd_insn, dx_opA<=opA_next, dx_opB<=opB_next.
- On a bubble, dx_pc, dx_opA and dx_opB may hold old values; downstream must qualify them with dx_valid.
- Latency: one cycle from F/D to D/X. Zero-cycle writeback bypass.
- fd_valid=0 propagates as a bubble and never raises hazard_stall.
- Reset asserted mid-stall: hazard_stall drops with dx_valid. On release, the first edge loads normally.
- Write and read of r0 in the same cycle: the result is 0 and the bypass is not taken.

Decomposition:
- Shared package/constants file holds: opcode constants (OP_LW, OP_SW, OP_BNE, OP_BLT, OP_JR) and instruction field bit positions, shared with fetch and execute.
- One natural sub-module: dx_bypass_mux. Instantiate it once per read port; its inputs are the read address, read data and the writeback triple.

Test Plan:
- Reset: hold ctrl_reset=0 with fd_valid=1 -> all dx_* = 0. Release, then fd_insn=add r3,r1,r2 with regfile r1=5, r2=7 -> next edge dx_opA=5, dx_opB=7, dx_valid=1.
- Bypass: decode add r4,r1,r1 while writeback writes r1=0x1234 -> dx_opA=dx_opB=0x1234. Same case with ctrl_writeReg=0 -> no bypass, operands=0.
- Remap: sw r6,0(r2) -> ctrl_readRegB=6, ctrl_readRegA=2. jr r31 -> ctrl_readRegA=31.
- Load-use: lw r5 in D/X, then add r7,r5,r1 in F/D -> hazard_stall=1 for exactly one cycle and dx_valid=0 that cycle. Next cycle the add latches with hazard_stall=0. lw r0 -> no stall.
- Flush priority: flush=1 and hazard_stall=1 in the same cycle -> dx_valid=0 and dx_insn=0. Next F/D instruction latches normally.
- Async reset mid-stream: drop ctrl_reset between edges during a stall -> dx_valid falls immediately without a clock edge.

Source files
------------

// File: rtl/dx_stage_pkg.sv
// Shared instruction-format constants for the fetch / decode / execute stages.
// Opcode encodings and bit positions of the opcode, rd, rs and rt fields.
package dx_stage_pkg;

    localparam int unsigned INSN_W = 32;
    localparam int unsigned RF_AW  = 5;

    localparam logic [4:0] OPC_LW  = 5'b01000;
    localparam logic [4:0] OPC_SW  = 5'b00111;
    localparam logic [4:0] OPC_BNE = 5'b00010;
    localparam logic [4:0] OPC_BLT = 5'b00110;
    localparam logic [4:0] OPC_JR  = 5'b00100;

    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 27;
    localparam int unsigned RD_HI  = 26;
    localparam int unsigned RD_LO  = 22;
    localparam int unsigned RS_HI  = 21;
    localparam int unsigned RS_LO  = 17;
    localparam int unsigned RT_HI  = 16;
    localparam int unsigned RT_LO  = 12;

endpackage

// File: rtl/dx_bypass_mux.sv
// Operand select for one regfile read port: same-cycle writeback bypass,
// with r0 hard-wired to zero.
module dx_bypass_mux
    import dx_stage_pkg::*;
#(
    parameter int unsigned DATA_W = INSN_W,
    parameter int unsigned REG_AW = RF_AW
) (
    input  logic [REG_AW-1:0] i_addr,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_wreg,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_op
);

    logic w_hit;

    // A write to r0 never forwards, so an r0 read still resolves to zero.
    assign w_hit = i_we && (i_wreg != '0) && (i_wreg == i_addr);

    always_comb begin
        o_op = i_rdata;
        if (w_hit) begin
            o_op = i_wdata;
        end else if (i_addr == '0) begin
            o_op = '0;
        end
    end

endmodule

// File: rtl/dx_stage.sv
// Decode-to-execute stage: drives regfile read addresses, bypasses writeback,
// detects load-use hazards and holds the D/X latch.
module dx_stage
    import dx_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = INSN_W,
    parameter int unsigned REG_AW  = RF_AW,
    parameter logic [4:0]  OP_LW   = OPC_LW,
    parameter logic [4:0]  OP_SW   = OPC_SW,
    parameter logic [4:0]  OP_BNE  = OPC_BNE,
    parameter logic [4:0]  OP_BLT  = OPC_BLT,
    parameter logic [4:0]  OP_JR   = OPC_JR
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              fd_valid,
    input  logic [DATA_W-1:0] fd_pc,
    input  logic [DATA_W-1:0] fd_insn,
    output logic [REG_AW-1:0] ctrl_readRegA,
    output logic [REG_AW-1:0] ctrl_readRegB,
    input  logic [DATA_W-1:0] data_readRegA,
    input  logic [DATA_W-1:0] data_readRegB,
    input  logic              ctrl_writeEnable,
    input  logic [REG_AW-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic              flush,
    output logic              hazard_stall,
    output logic              dx_valid,
    output logic [DATA_W-1:0] dx_pc,
    output logic [DATA_W-1:0] dx_insn,
    output logic [DATA_W-1:0] dx_opA,
    output logic [DATA_W-1:0] dx_opB
);

    logic [4:0]        w_opc;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic              w_b_uses_rd;
    logic [4:0]        w_dx_opc;
    logic [REG_AW-1:0] w_dx_rd;
    logic [DATA_W-1:0] w_opA_next;
    logic [DATA_W-1:0] w_opB_next;

    logic              r_valid;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_insn;
    logic [DATA_W-1:0] r_opA;
    logic [DATA_W-1:0] r_opB;

    assign w_opc = fd_insn[OPC_HI:OPC_LO];
    assign w_rd  = fd_insn[RD_HI:RD_LO];
    assign w_rs  = fd_insn[RS_HI:RS_LO];
    assign w_rt  = fd_insn[RT_HI:RT_LO];

    // Stores and compare-branches read their second source from the rd field.
    assign w_b_uses_rd   = (w_opc == OP_SW) || (w_opc == OP_BNE) || (w_opc == OP_BLT);
    assign ctrl_readRegA = (w_opc == OP_JR) ? w_rd : w_rs;
    assign ctrl_readRegB = w_b_uses_rd ? w_rd : w_rt;

    dx_bypass_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_byp_a (
        .i_addr  (ctrl_readRegA),
        .i_rdata (data_readRegA),
        .i_we    (ctrl_writeEnable),
        .i_wreg  (ctrl_writeReg),
        .i_wdata (data_writeReg),
        .o_op    (w_opA_next)
    );

    dx_bypass_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_byp_b (
        .i_addr  (ctrl_readRegB),
        .i_rdata (data_readRegB),
        .i_we    (ctrl_writeEnable),
        .i_wreg  (ctrl_writeReg),
        .i_wdata (data_writeReg),
        .o_op    (w_opB_next)
    );

    assign w_dx_opc = r_insn[OPC_HI:OPC_LO];
    assign w_dx_rd  = r_insn[RD_HI:RD_LO];

    assign hazard_stall = r_valid && fd_valid && (w_dx_opc == OP_LW) && (w_dx_rd != '0) &&
                          ((w_dx_rd == ctrl_readRegA) || (w_dx_rd == ctrl_readRegB));

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_insn  <= '0;
            r_opA   <= '0;
            r_opB   <= '0;
        end else if (flush || hazard_stall) begin
            r_valid <= 1'b0;
            r_insn  <= '0;
        end else begin
            r_valid <= fd_valid;
            r_pc    <= fd_pc;
            r_insn  <= fd_insn;
            r_opA   <= w_opA_next;
            r_opB   <= w_opB_next;
        end
    end

    assign dx_valid = r_valid;
    assign dx_pc    = r_pc;
    assign dx_insn  = r_insn;
    assign dx_opA   = r_opA;
    assign dx_opB   = r_opB;

endmodule

// File: tb/tb_dx_stage.sv
// Directed bench for dx_stage: expected D/X contents are queued at issue time
// and checked by a negedge monitor whenever dx_valid is high.
module tb_dx_stage;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        fd_valid;
    logic [31:0] fd_pc;
    logic [31:0] fd_insn;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        flush;
    logic        hazard_stall;
    logic        dx_valid;
    logic [31:0] dx_pc;
    logic [31:0] dx_insn;
    logic [31:0] dx_opA;
    logic [31:0] dx_opB;

    logic [31:0] rf [32];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        sbq[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clock = ~clock;

    dx_stage dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .fd_valid         (fd_valid),
        .fd_pc            (fd_pc),
        .fd_insn          (fd_insn),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .flush            (flush),
        .hazard_stall     (hazard_stall),
        .dx_valid         (dx_valid),
        .dx_pc            (dx_pc),
        .dx_insn          (dx_insn),
        .dx_opA           (dx_opA),
        .dx_opB           (dx_opB)
    );

    // Regfile model: returns stored contents, including a non-zero r0 value.
    always_comb begin
        data_readRegA = rf[ctrl_readRegA];
        data_readRegB = rf[ctrl_readRegB];
    end

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [11:0] imm);
        return {op, rd, rs, rt, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] insn);
        fd_valid = v;
        fd_pc    = pc;
        fd_insn  = insn;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] insn,
                        input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.pc   = pc;
        e.insn = insn;
        e.a    = a;
        e.b    = b;
        sbq.push_back(e);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (dx_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got pc %h expected no valid output", dx_pc);
            end else begin
                e = sbq.pop_front();
                chk("dx_pc", dx_pc, e.pc);
                chk("dx_insn", dx_insn, e.insn);
                chk("dx_opA", dx_opA, e.a);
                chk("dx_opB", dx_opB, e.b);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    localparam logic [4:0] ADD = 5'b00000;
    localparam logic [4:0] LW  = 5'b01000;
    localparam logic [4:0] SW  = 5'b00111;
    localparam logic [4:0] BNE = 5'b00010;
    localparam logic [4:0] BLT = 5'b00110;
    localparam logic [4:0] JR  = 5'b00100;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[0]  = 32'hDEAD_BEEF;
        rf[1]  = 32'd5;
        rf[2]  = 32'd7;
        rf[4]  = 32'h44;
        rf[5]  = 32'h55;
        rf[6]  = 32'h66;
        rf[31] = 32'h1F00;

        ctrl_reset       = 1'b0;
        flush            = 1'b0;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'h0;
        drive(1'b1, 32'h100, mk(ADD, 5'd3, 5'd1, 5'd2, 12'h0));

        repeat (2) tick;
        chk("rst_valid", {31'b0, dx_valid}, 32'd0);
        chk("rst_pc", dx_pc, 32'h0);
        chk("rst_insn", dx_insn, 32'h0);
        chk("rst_opA", dx_opA, 32'h0);
        chk("rst_opB", dx_opB, 32'h0);

        ctrl_reset = 1'b1;
        #1;
        chk("add_raddrA", {27'b0, ctrl_readRegA}, 32'd1);
        chk("add_raddrB", {27'b0, ctrl_readRegB}, 32'd2);
        push(32'h100, mk(ADD, 5'd3, 5'd1, 5'd2, 12'h0), 32'd5, 32'd7);
        tick;

        drive(1'b1, 32'h104, mk(ADD, 5'd4, 5'd1, 5'd1, 12'h0));
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd1;
        data_writeReg    = 32'h1234;
        push(32'h104, mk(ADD, 5'd4, 5'd1, 5'd1, 12'h0), 32'h1234, 32'h1234);
        tick;

        drive(1'b1, 32'h108, mk(ADD, 5'd4, 5'd0, 5'd0, 12'h0));
        ctrl_writeReg = 5'd0;
        push(32'h108, mk(ADD, 5'd4, 5'd0, 5'd0, 12'h0), 32'h0, 32'h0);
        tick;

        drive(1'b1, 32'h10C, mk(ADD, 5'd8, 5'd1, 5'd2, 12'h0));
        ctrl_writeReg = 5'd2;
        data_writeReg = 32'hABCD;
        push(32'h10C, mk(ADD, 5'd8, 5'd1, 5'd2, 12'h0), 32'd5, 32'hABCD);
        tick;
        ctrl_writeEnable = 1'b0;

        drive(1'b1, 32'h110, mk(SW, 5'd6, 5'd2, 5'd9, 12'h010));
        #1;
        chk("sw_raddrA", {27'b0, ctrl_readRegA}, 32'd2);
        chk("sw_raddrB", {27'b0, ctrl_readRegB}, 32'd6);
        push(32'h110, mk(SW, 5'd6, 5'd2, 5'd9, 12'h010), 32'd7, 32'h66);
        tick;

        drive(1'b1, 32'h114, mk(JR, 5'd31, 5'd3, 5'd4, 12'h0));
        #1;
        chk("jr_raddrA", {27'b0, ctrl_readRegA}, 32'd31);
        chk("jr_raddrB", {27'b0, ctrl_readRegB}, 32'd4);
        push(32'h114, mk(JR, 5'd31, 5'd3, 5'd4, 12'h0), 32'h1F00, 32'h44);
        tick;

        drive(1'b1, 32'h118, mk(BNE, 5'd5, 5'd1, 5'd4, 12'h0));
        #1;
        chk("bne_raddrB", {27'b0, ctrl_readRegB}, 32'd5);
        push(32'h118, mk(BNE, 5'd5, 5'd1, 5'd4, 12'h0), 32'd5, 32'h55);
        tick;

        drive(1'b1, 32'h11A, mk(BLT, 5'd6, 5'd2, 5'd4, 12'h0));
        #1;
        chk("blt_raddrB", {27'b0, ctrl_readRegB}, 32'd6);
        push(32'h11A, mk(BLT, 5'd6, 5'd2, 5'd4, 12'h0), 32'd7, 32'h66);
        tick;

        // Load-use on port A: one bubble, then the dependent add latches.
        drive(1'b1, 32'h11C, mk(LW, 5'd5, 5'd1, 5'd0, 12'h004));
        push(32'h11C, mk(LW, 5'd5, 5'd1, 5'd0, 12'h004), 32'd5, 32'h0);
        tick;
        drive(1'b1, 32'h120, mk(ADD, 5'd7, 5'd5, 5'd1, 12'h0));
        #1;
        chk("lu_stall", {31'b0, hazard_stall}, 32'd1);
        tick;
        chk("lu_bubble_valid", {31'b0, dx_valid}, 32'd0);
        chk("lu_bubble_insn", dx_insn, 32'h0);
        chk("lu_stall_drop", {31'b0, hazard_stall}, 32'd0);
        push(32'h120, mk(ADD, 5'd7, 5'd5, 5'd1, 12'h0), 32'h55, 32'd5);
        tick;

        drive(1'b1, 32'h124, mk(LW, 5'd0, 5'd2, 5'd0, 12'h0));
        push(32'h124, mk(LW, 5'd0, 5'd2, 5'd0, 12'h0), 32'd7, 32'h0);
        tick;
        drive(1'b1, 32'h128, mk(ADD, 5'd7, 5'd0, 5'd1, 12'h0));
        #1;
        chk("lw_r0_nostall", {31'b0, hazard_stall}, 32'd0);
        push(32'h128, mk(ADD, 5'd7, 5'd0, 5'd1, 12'h0), 32'h0, 32'd5);
        tick;

        drive(1'b1, 32'h12C, mk(LW, 5'd5, 5'd1, 5'd0, 12'h0));
        push(32'h12C, mk(LW, 5'd5, 5'd1, 5'd0, 12'h0), 32'd5, 32'h0);
        tick;
        drive(1'b0, 32'h130, mk(ADD, 5'd7, 5'd5, 5'd1, 12'h0));
        #1;
        chk("fdinv_nostall", {31'b0, hazard_stall}, 32'd0);
        tick;
        chk("fdinv_bubble", {31'b0, dx_valid}, 32'd0);

        // Flush together with a port-B load-use stall.
        drive(1'b1, 32'h134, mk(LW, 5'd5, 5'd1, 5'd0, 12'h0));
        push(32'h134, mk(LW, 5'd5, 5'd1, 5'd0, 12'h0), 32'd5, 32'h0);
        tick;
        drive(1'b1, 32'h138, mk(ADD, 5'd7, 5'd1, 5'd5, 12'h0));
        flush = 1'b1;
        #1;
        chk("flush_stall_B", {31'b0, hazard_stall}, 32'd1);
        tick;
        flush = 1'b0;
        chk("flush_valid", {31'b0, dx_valid}, 32'd0);
        chk("flush_insn", dx_insn, 32'h0);
        drive(1'b1, 32'h200, mk(ADD, 5'd3, 5'd1, 5'd2, 12'h0));
        push(32'h200, mk(ADD, 5'd3, 5'd1, 5'd2, 12'h0), 32'd5, 32'd7);
        tick;

        // Asynchronous reset between edges while a stall is pending.
        drive(1'b1, 32'h204, mk(LW, 5'd5, 5'd1, 5'd0, 12'h0));
        push(32'h204, mk(LW, 5'd5, 5'd1, 5'd0, 12'h0), 32'd5, 32'h0);
        tick;
        drive(1'b1, 32'h208, mk(ADD, 5'd7, 5'd5, 5'd1, 12'h0));
        #1;
        chk("ar_stall", {31'b0, hazard_stall}, 32'd1);
        @(negedge clock);
        #1;
        ctrl_reset = 1'b0;
        #1;
        chk("ar_valid", {31'b0, dx_valid}, 32'd0);
        chk("ar_stall_drop", {31'b0, hazard_stall}, 32'd0);
        chk("ar_insn", dx_insn, 32'h0);
        chk("ar_opA", dx_opA, 32'h0);
        tick;
        ctrl_reset = 1'b1;
        push(32'h208, mk(ADD, 5'd7, 5'd5, 5'd1, 12'h0), 32'h55, 32'd5);
        tick;

        drive(1'b0, 32'h0, 32'h0);
        repeat (3) tick;
        chk("sb_drained", sbq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
